// File: rtl/sprite_pkg.sv
// -----------------------------------------------------------------------------
// sprite_pkg
// Shared types and helpers for the animated sprite engine.
//   anim_state_t : frame sequencer states (IDLE, PLAY, DONE)
//   SCREEN_W/H   : visible VGA raster size
//   frame_base() : first ROM address of animation frame f
// -----------------------------------------------------------------------------
package sprite_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLAY = 2'd1,
        DONE = 2'd2
    } anim_state_t;

    localparam int SCREEN_W = 640;
    localparam int SCREEN_H = 480;

    // Frames are packed back-to-back, so frame f starts at f * w * h.
    function automatic int unsigned frame_base(input int unsigned f,
                                               input int unsigned w,
                                               input int unsigned h);
        return f * w * h;
    endfunction

endpackage

// File: rtl/anim_sequencer.sv
// -----------------------------------------------------------------------------
// anim_sequencer
// Steps the animation frame on vsync rising edges.
// Ports:
//   vga_clk, reset_n : pixel clock, asynchronous active-low reset
//   vs               : vertical sync (active-low pulse)
//   start            : 1-cycle pulse, (re)start at frame 0 from any state
//   loop_en          : 1 = wrap to frame 0 after the last frame, 0 = one-shot
//   frame            : current frame number
//   busy             : high while in PLAY
//   done             : 1-cycle pulse when a one-shot run finishes
// -----------------------------------------------------------------------------
module anim_sequencer
    import sprite_pkg::*;
#(
    parameter int NUM_FRAMES  = 4,
    parameter int HOLD_VSYNCS = 6,
    parameter int FRAME_W     = 2
) (
    input  logic               vga_clk,
    input  logic               reset_n,
    input  logic               vs,
    input  logic               start,
    input  logic               loop_en,
    output logic [FRAME_W-1:0] frame,
    output logic               busy,
    output logic               done
);

    localparam int HOLD_W = (HOLD_VSYNCS > 1) ? $clog2(HOLD_VSYNCS) : 1;

    anim_state_t        state_q, state_d;
    logic [FRAME_W-1:0] frame_q, frame_d;
    logic [HOLD_W-1:0]  hold_q, hold_d;
    logic               done_q, done_d;
    logic               vs_q, vs_d;
    logic               vs_prev_q, vs_prev_d;
    logic               tick;

    // vs is registered twice; a 0 -> 1 step between the two copies is the
    // end of the sync pulse. Both reset high (idle sync level) so leaving
    // reset never produces a phantom tick.
    assign tick = vs_q & ~vs_prev_q;

    // NOTE: every signal written here is given a default first, so no path
    // leaves a value unassigned and no latch is inferred.
    always_comb begin
        state_d   = state_q;
        frame_d   = frame_q;
        hold_d    = hold_q;
        done_d    = 1'b0;
        vs_d      = vs;
        vs_prev_d = vs_q;

        // start has priority over a coincident tick.
        if (start) begin
            state_d = PLAY;
            frame_d = '0;
            hold_d  = '0;
        end else if (tick && (state_q == PLAY)) begin
            if (hold_q == HOLD_W'(HOLD_VSYNCS - 1)) begin
                hold_d = '0;
                if (frame_q < FRAME_W'(NUM_FRAMES - 1)) begin
                    frame_d = frame_q + FRAME_W'(1);
                end else if (loop_en) begin
                    frame_d = '0;
                end else begin
                    state_d = DONE;
                    done_d  = 1'b1;
                end
            end else begin
                hold_d = hold_q + HOLD_W'(1);
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples its _d value from before the edge, independent of statement
    // order. Only control state lives here, so all of it is reset.
    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            frame_q   <= '0;
            hold_q    <= '0;
            done_q    <= 1'b0;
            vs_q      <= 1'b1;
            vs_prev_q <= 1'b1;
        end else begin
            state_q   <= state_d;
            frame_q   <= frame_d;
            hold_q    <= hold_d;
            done_q    <= done_d;
            vs_q      <= vs_d;
            vs_prev_q <= vs_prev_d;
        end
    end

    assign frame = frame_q;
    assign busy  = (state_q == PLAY);
    assign done  = done_q;

endmodule

// File: rtl/anim_sprite_engine.sv
// -----------------------------------------------------------------------------
// anim_sprite_engine
// Draws one animated, power-of-two scaled sprite from an external synchronous
// ROM holding NUM_FRAMES frames back-to-back, with index-based transparency.
// Build option: define SPRITE_HFLIP_EN to honour the hflip input; otherwise
// hflip is ignored (the port stays so instantiations do not change).
// Ports:
//   vga_clk, reset_n      : pixel clock, asynchronous active-low reset
//   DrawX, DrawY          : current raster position
//   SprX, SprY            : sprite top-left corner on screen
//   blank                 : high during active video
//   vs                    : vertical sync, active-low pulse
//   start, loop_en        : sequencer control (see anim_sequencer)
//   hflip                 : horizontal mirror
//   rom_address / rom_q   : sprite ROM, data valid one clock after address
//   pal_index / pal_r,g,b : combinational palette lookup
//   red, green, blue      : pixel colour, zero where the sprite is absent
//   sprite_on             : pixel owned by the sprite
//   frame, busy, done     : sequencer status
// Latency from DrawX/DrawY to colour/sprite_on is two clocks.
// -----------------------------------------------------------------------------
module anim_sprite_engine
    import sprite_pkg::*;
#(
    parameter int SPR_W       = 64,
    parameter int SPR_H       = 64,
    parameter int NUM_FRAMES  = 4,
    parameter int SCALE_SHIFT = 1,
    parameter int HOLD_VSYNCS = 6,
    parameter int ADDR_W      = 15,
    parameter int IDX_W       = 4,
    parameter int TRANSP_IDX  = 0,
    localparam int FRAME_W    = (NUM_FRAMES > 1) ? $clog2(NUM_FRAMES) : 1
) (
    input  logic               vga_clk,
    input  logic               reset_n,
    input  logic [9:0]         DrawX,
    input  logic [9:0]         DrawY,
    input  logic [9:0]         SprX,
    input  logic [9:0]         SprY,
    input  logic               blank,
    input  logic               vs,
    input  logic               start,
    input  logic               loop_en,
    input  logic               hflip,
    output logic [ADDR_W-1:0]  rom_address,
    input  logic [IDX_W-1:0]   rom_q,
    output logic [IDX_W-1:0]   pal_index,
    input  logic [3:0]         pal_r,
    input  logic [3:0]         pal_g,
    input  logic [3:0]         pal_b,
    output logic [3:0]         red,
    output logic [3:0]         green,
    output logic [3:0]         blue,
    output logic               sprite_on,
    output logic [FRAME_W-1:0] frame,
    output logic               busy,
    output logic               done
);

    localparam int SCR_W = SPR_W << SCALE_SHIFT;
    localparam int SCR_H = SPR_H << SCALE_SHIFT;

    // ---------------------------------------------------------------- sequencer
    anim_sequencer #(
        .NUM_FRAMES  (NUM_FRAMES),
        .HOLD_VSYNCS (HOLD_VSYNCS),
        .FRAME_W     (FRAME_W)
    ) u_seq (
        .vga_clk (vga_clk),
        .reset_n (reset_n),
        .vs      (vs),
        .start   (start),
        .loop_en (loop_en),
        .frame   (frame),
        .busy    (busy),
        .done    (done)
    );

    // ---------------------------------------------------------------- mirror
    logic hflip_eff;
`ifdef SPRITE_HFLIP_EN
    assign hflip_eff = hflip;
`else
    logic unused_hflip;
    assign hflip_eff    = 1'b0;
    assign unused_hflip = hflip;
`endif

    // ---------------------------------------------------------------- stage 0
    // Coordinates are widened to 11 bits so SprX + on-screen width never
    // wraps when the sprite hangs off the right or bottom edge.
    logic [10:0]       dx, dy, sx, sy, rel_x, rel_y;
    logic              in_box;
    logic [ADDR_W-1:0] lx_a, ly_a, base_a;
    logic [ADDR_W-1:0] rom_address_q, rom_address_d;
    logic              s1_hit_q, s1_hit_d, s1_blank_q, s1_blank_d;
    logic              s2_hit_q, s2_hit_d, s2_blank_q, s2_blank_d;

    always_comb begin
        dx     = {1'b0, DrawX};
        dy     = {1'b0, DrawY};
        sx     = {1'b0, SprX};
        sy     = {1'b0, SprY};
        rel_x  = dx - sx;
        rel_y  = dy - sy;
        in_box = (dx >= sx) && (dx < sx + 11'(SCR_W)) &&
                 (dy >= sy) && (dy < sy + 11'(SCR_H));

        lx_a = ADDR_W'(rel_x >> SCALE_SHIFT);
        ly_a = ADDR_W'(rel_y >> SCALE_SHIFT);
        if (hflip_eff) begin
            lx_a = ADDR_W'(SPR_W - 1) - lx_a;
        end
        base_a = ADDR_W'(frame_base(32'(frame), SPR_W, SPR_H));

        rom_address_d = in_box ? (base_a + ly_a * ADDR_W'(SPR_W) + lx_a) : '0;
        s1_hit_d      = in_box;
        s1_blank_d    = blank;
        // Second flag stage lines the hit/blank qualifiers up with rom_q.
        s2_hit_d      = s1_hit_q;
        s2_blank_d    = s1_blank_q;
    end

    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            rom_address_q <= '0;
            s1_hit_q      <= 1'b0;
            s1_blank_q    <= 1'b0;
            s2_hit_q      <= 1'b0;
            s2_blank_q    <= 1'b0;
        end else begin
            rom_address_q <= rom_address_d;
            s1_hit_q      <= s1_hit_d;
            s1_blank_q    <= s1_blank_d;
            s2_hit_q      <= s2_hit_d;
            s2_blank_q    <= s2_blank_d;
        end
    end

    assign rom_address = rom_address_q;

    // ---------------------------------------------------------------- output
    // rom_q is already the ROM's registered data, so colour is formed from it
    // and the aligned flag flops without a further register; this keeps the
    // total latency at two clocks and the cleared flags force the outputs to
    // zero as soon as reset asserts.
    logic pix_on;

    assign pal_index = rom_q;
    assign pix_on    = s2_hit_q && s2_blank_q && (rom_q != IDX_W'(TRANSP_IDX));
    assign sprite_on = pix_on;
    assign red       = pix_on ? pal_r : 4'h0;
    assign green     = pix_on ? pal_g : 4'h0;
    assign blue      = pix_on ? pal_b : 4'h0;

endmodule

// File: tb/tb_anim_sprite_engine.sv
// -----------------------------------------------------------------------------
// tb_anim_sprite_engine
// Self-checking bench for anim_sprite_engine with default parameters. Holds a
// ROM image and palette of its own and predicts pixels and frame numbers from
// plain arithmetic on sprite geometry and vsync counts.
// -----------------------------------------------------------------------------
module tb_anim_sprite_engine;

    localparam int SPR_W  = 64;
    localparam int SPR_H  = 64;
    localparam int NF     = 4;
    localparam int SCALE  = 2;   // 1 << SCALE_SHIFT
    localparam int HOLD   = 6;
    localparam int FRAME_SZ = SPR_W * SPR_H;

    logic        vga_clk = 1'b0;
    logic        reset_n;
    logic [9:0]  DrawX, DrawY, SprX, SprY;
    logic        blank, vs, start, loop_en, hflip;
    logic [14:0] rom_address;
    logic [3:0]  rom_q;
    logic [3:0]  pal_index, pal_r, pal_g, pal_b;
    logic [3:0]  red, green, blue;
    logic        sprite_on;
    logic [1:0]  frame;
    logic        busy, done;

    logic [3:0]  rom_mem [0:32767];

    int checks = 0;
    int errors = 0;
    int done_seen = 0;

    // reference sequencer state
    int m_frame = 0;
    int m_n     = 0;
    int m_done  = 0;
    bit m_play  = 1'b0;

    always #5 vga_clk = ~vga_clk;

    anim_sprite_engine dut (
        .vga_clk     (vga_clk),
        .reset_n     (reset_n),
        .DrawX       (DrawX),
        .DrawY       (DrawY),
        .SprX        (SprX),
        .SprY        (SprY),
        .blank       (blank),
        .vs          (vs),
        .start       (start),
        .loop_en     (loop_en),
        .hflip       (hflip),
        .rom_address (rom_address),
        .rom_q       (rom_q),
        .pal_index   (pal_index),
        .pal_r       (pal_r),
        .pal_g       (pal_g),
        .pal_b       (pal_b),
        .red         (red),
        .green       (green),
        .blue        (blue),
        .sprite_on   (sprite_on),
        .frame       (frame),
        .busy        (busy),
        .done        (done)
    );

    // synchronous ROM and combinational palette
    always @(posedge vga_clk) rom_q <= rom_mem[rom_address];
    assign pal_r = pal_index ^ 4'hA;
    assign pal_g = pal_index + 4'd7;
    assign pal_b = ~pal_index;

    always @(posedge vga_clk) if (done === 1'b1) done_seen <= done_seen + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit m_inbox(int dx, int dy, int sx, int sy);
        return dx >= sx && dx < sx + SPR_W * SCALE && dy >= sy && dy < sy + SPR_H * SCALE;
    endfunction

    function automatic int m_addr(int dx, int dy, int sx, int sy, bit hf, int fr);
        int lx, ly;
        if (!m_inbox(dx, dy, sx, sy)) return 0;
        lx = (dx - sx) / SCALE;
        ly = (dy - sy) / SCALE;
`ifdef SPRITE_HFLIP_EN
        if (hf) lx = SPR_W - 1 - lx;
`else
        if (hf) lx = lx + 0;
`endif
        return fr * FRAME_SZ + ly * SPR_W + lx;
    endfunction

    // Hold one raster position for two clocks and check address and colour.
    task automatic pix(input string tag, input int dx, input int dy, input int sx,
                       input int sy, input bit bl, input bit hf);
        int ea;
        bit on;
        logic [3:0] idx;
        @(posedge vga_clk); #1;
        DrawX = 10'(dx); DrawY = 10'(dy); SprX = 10'(sx); SprY = 10'(sy);
        blank = bl; hflip = hf;
        ea  = m_addr(dx, dy, sx, sy, hf, m_frame);
        idx = rom_mem[ea];
        on  = bl && m_inbox(dx, dy, sx, sy) && (idx != 4'd0);
        @(posedge vga_clk); #1;
        check({tag, "_addr"}, 32'(rom_address), 32'(ea));
        @(posedge vga_clk); #1;
        check({tag, "_on"}, 32'(sprite_on), 32'(on));
        check({tag, "_red"}, 32'(red), on ? 32'(idx ^ 4'hA) : 32'd0);
        check({tag, "_green"}, 32'(green), on ? 32'(4'(idx + 4'd7)) : 32'd0);
        check({tag, "_blue"}, 32'(blue), on ? 32'(4'(~idx)) : 32'd0);
    endtask

    task automatic rand_pix(input string tag, input int n);
        for (int i = 0; i < n; i++) begin
            int sx, sy, dx, dy;
            sx = int'($urandom_range(0, 600));
            sy = int'($urandom_range(0, 400));
            dx = sx + int'($urandom_range(0, 140)) - 6;
            dy = sy + int'($urandom_range(0, 140)) - 6;
            if (dx < 0) dx = 0;
            if (dy < 0) dy = 0;
            pix(tag, dx, dy, sx, sy, ($urandom_range(0, 7) != 0), 1'($urandom_range(0, 1)));
        end
    endtask

    task automatic do_start();
        @(posedge vga_clk); #1 start = 1'b1;
        @(posedge vga_clk); #1 start = 1'b0;
        m_play = 1'b1; m_frame = 0; m_n = 0;
    endtask

    task automatic model_tick();
        if (m_play) begin
            m_n++;
            if (m_n % HOLD == 0) begin
                if (m_frame < NF - 1) m_frame++;
                else if (loop_en) m_frame = 0;
                else begin m_play = 1'b0; m_done++; end
            end
        end
    endtask

    task automatic vsync_pulse(input string tag);
        @(posedge vga_clk); #1 vs = 1'b0;
        repeat (2) @(posedge vga_clk);
        #1 vs = 1'b1;
        repeat (4) @(posedge vga_clk);
        #1;
        model_tick();
        check({tag, "_frame"}, 32'(frame), 32'(m_frame));
        check({tag, "_busy"}, 32'(busy), 32'(m_play));
        check({tag, "_done"}, 32'(done_seen), 32'(m_done));
    endtask

    initial begin
        for (int i = 0; i < 32768; i++) rom_mem[i] = 4'($urandom_range(0, 15));
        rom_mem[129] = 4'h5;
        reset_n = 1'b0; vs = 1'b1; start = 1'b0; loop_en = 1'b0; hflip = 1'b0;
        blank = 1'b1; DrawX = '0; DrawY = '0; SprX = 10'd700; SprY = 10'd700;
        repeat (3) @(posedge vga_clk);
        #1 reset_n = 1'b1;
        check("rst_frame", 32'(frame), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_on", 32'(sprite_on), 32'd0);
        check("rst_red", 32'(red), 32'd0);

        // directed pixels
        pix("px129", 103, 205, 100, 200, 1'b1, 1'b0);
        check("px129_exact", 32'(m_addr(103, 205, 100, 200, 1'b0, 0)), 32'd129);
        rom_mem[129] = 4'h0;
        pix("transp", 103, 205, 100, 200, 1'b1, 1'b0);
        rom_mem[129] = 4'h5;
        pix("left_out", 99, 205, 100, 200, 1'b1, 1'b0);
        pix("right_out", 228, 205, 100, 200, 1'b1, 1'b0);
        pix("right_in", 227, 205, 100, 200, 1'b1, 1'b0);
        pix("bot_out", 150, 328, 100, 200, 1'b1, 1'b0);
        pix("blank0", 103, 205, 100, 200, 1'b0, 1'b0);
        pix("wrap11", 1000, 470, 960, 440, 1'b1, 1'b0);
        pix("edge639", 639, 10, 600, 0, 1'b1, 1'b0);
        pix("hflip", 100, 200, 100, 200, 1'b1, 1'b1);
`ifdef SPRITE_HFLIP_EN
        check("hflip_col", 32'(rom_address % 15'(SPR_W)), 32'd63);
`else
        check("hflip_col", 32'(rom_address % 15'(SPR_W)), 32'd0);
`endif
        rand_pix("rnd0", 30);

        // idle: vsync without start leaves frame alone
        vsync_pulse("idle");

        // one-shot through all frames
        loop_en = 1'b0;
        do_start();
        check("os_start_busy", 32'(busy), 32'd1);
        for (int i = 0; i < NF * HOLD; i++) vsync_pulse("oneshot");
        check("os_done_once", 32'(done_seen), 32'd1);
        vsync_pulse("os_after");
        vsync_pulse("os_after");
        rand_pix("rnd3", 10);

        // reset mid-line while the sprite is visible at frame 3
        rom_mem[3 * FRAME_SZ + 129] = 4'h9;
        pix("pre_rst", 103, 205, 100, 200, 1'b1, 1'b0);
        #3 reset_n = 1'b0;
        #1;
        check("mid_rst_on", 32'(sprite_on), 32'd0);
        check("mid_rst_rgb", 32'({red, green, blue}), 32'd0);
        check("mid_rst_frame", 32'(frame), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        @(posedge vga_clk); #1 reset_n = 1'b1;
        m_frame = 0; m_play = 1'b0; m_n = 0;
        for (int i = 0; i < 3; i++) vsync_pulse("post_rst");

        // looping: wraps 3 -> 0 without done
        loop_en = 1'b1;
        do_start();
        for (int i = 0; i < NF * HOLD + 14; i++) vsync_pulse("loop");

        // start coincident with a tick: start wins, hold restarts
        @(posedge vga_clk); #1 vs = 1'b0;
        repeat (2) @(posedge vga_clk);
        #1 vs = 1'b1;
        @(posedge vga_clk); #1 start = 1'b1;
        @(posedge vga_clk); #1 start = 1'b0;
        m_play = 1'b1; m_frame = 0; m_n = 0;
        repeat (3) @(posedge vga_clk);
        #1;
        check("coinc_frame", 32'(frame), 32'd0);
        check("coinc_busy", 32'(busy), 32'd1);
        for (int i = 0; i < HOLD; i++) vsync_pulse("coinc");
        check("coinc_step", 32'(frame), 32'd1);

        // loop_en dropped: stops at the next last-frame boundary
        loop_en = 1'b0;
        for (int i = 0; i < 3 * HOLD + 2; i++) vsync_pulse("stop");
        check("stop_done_total", 32'(done_seen), 32'd2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/anim_sprite_engine.md
Name: anim_sprite_engine

Overview:
- Parametrised successor to the single-image sprite drawers: one sprite with NUM_FRAMES animation frames stored back-to-back in an external synchronous ROM.
- Power-of-two scaling, index-based transparency, and a frame sequencer (one-shot or loop) stepped on vsync.
- Sits between the VGA controller and the colour mux; one instance per character animation (walk, punch, death, ...).

Parameters:
- SPR_W, 64, source sprite width in pixels (power of two).
- SPR_H, 64, source sprite height in pixels.
- NUM_FRAMES, 4, frames in ROM; frame f occupies addresses f*SPR_W*SPR_H onward.
- SCALE_SHIFT, 1, on-screen size = source << SCALE_SHIFT.
- HOLD_VSYNCS, 6, vsync rising edges each frame is shown.
- ADDR_W, 15, ROM address width; must be >= clog2(NUM_FRAMES*SPR_W*SPR_H).
- IDX_W, 4, palette index width.
- TRANSP_IDX, 0, palette index treated as transparent.

Ports:
- vga_clk  in  1  pixel clock
- reset_n  in  1  asynchronous, active-low reset
- DrawX, DrawY  in  10 each  current pixel
- SprX, SprY  in  10 each  sprite top-left on screen
- blank  in  1  high = active video
- vs  in  1  vertical sync, active-low pulse
- start  in  1  1-cycle pulse, begin animation at frame 0
- loop_en  in  1  1 = loop, 0 = one-shot
- hflip  in  1  mirror horizontally (see Optional Feature)
- rom_address  out  ADDR_W  to ROM
- rom_q  in  IDX_W  ROM data, valid 1 vga_clk after address
- pal_index  out  IDX_W  to combinational palette
- pal_r, pal_g, pal_b  in  4 each  palette output
- red, green, blue  out  4 each  pixel colour
- sprite_on  out  1  pixel owned by sprite
- frame  out  clog2(NUM_FRAMES)  current frame
- busy  out  1  sequencer in PLAY
- done  out  1  1-cycle pulse when a one-shot finishes

Behaviour:
- Reset: red/green/blue=0, sprite_on=0, frame=0, busy=0, done=0, hold counter=0, FSM=IDLE, pipeline valids=0. Reset may assert mid-frame; outputs go to 0 immediately.
- Hit test (stage 0): in_box = DrawX>=SprX && DrawX<SprX+(SPR_W<<SCALE_SHIFT) && same for Y. Compare in 11 bits so SprX+width > 639 does not wrap.
- Local coords: lx=(DrawX-SprX)>>SCALE_SHIFT, ly=(DrawY-SprY)>>SCALE_SHIFT. With hflip, lx'=SPR_W-1-lx.
- Address: rom_address = frame*SPR_W*SPR_H + ly*SPR_W + lx', registered on vga_clk; 0 when !in_box.
- Stage 1: rom_q arrives; in_box and blank are delayed to match. pal_index = rom_q.
- Stage 2: registered output. If delayed blank && in_box && rom_q != TRANSP_IDX, drive red/green/blue = pal_*, sprite_on=1; else all 0.
- Latency: DrawX/DrawY to red/green/blue/sprite_on is 2 cycles. The VGA controller compensates.
- vsync edge: vs is registered, and tick = previous 0, current 1. All sequencer actions happen only on tick, except start.
- FSM states:
  - IDLE: frame holds. start -> PLAY, frame=0, hold=0.
  - PLAY: on tick, hold++. When hold==HOLD_VSYNCS-1: hold=0. If frame<NUM_FRAMES-1 then frame++; else if loop_en then frame=0; else -> DONE with a done pulse.
  - DONE: frame stays at NUM_FRAMES-1. start -> PLAY at frame 0.
- busy = (state==PLAY).
- start in any state restarts at frame 0. start and tick in the same cycle: start wins and the tick is ignored.
- frame changes only on tick, so no mid-screen tearing, provided start is issued during blanking.
- loop_en is sampled at the last-frame boundary.

Optional Feature:
- Macro SPRITE_HFLIP_EN.
- Defined: hflip port is honoured as above.
- Undefined: hflip is ignored (tied off internally) and lx'=lx. The port remains so instantiations are unchanged.

Decomposition:
- Package sprite_pkg: anim_state_t enum (IDLE, PLAY, DONE); constant SCREEN_W=640, SCREEN_H=480; function for frame base address.
- One sub-module, anim_sequencer: vsync edge detect, hold counter, FSM, frame/busy/done outputs.
- Rendering pipeline stays in the top.

Test Plan:
- Reset low mid-line with sprite visible -> red/green/blue=0, sprite_on=0, frame=0 within the same cycle. After release with no start, frame stays 0.
- SprX=100, SprY=200, SCALE_SHIFT=1, frame=0, DrawX=103, DrawY=205 -> rom_address=2*64+1=129 one cycle later; colour of ROM[129] 2 cycles after the draw coordinates.
- ROM[129]=TRANSP_IDX -> sprite_on=0. DrawX=99 or DrawX=228 -> rom_address=0, sprite_on=0. blank=0 -> sprite_on=0.
- loop_en=0, start, 24 vsync pulses (HOLD_VSYNCS=6, NUM_FRAMES=4) -> frame steps 0,1,2,3 every 6 ticks; done pulses once at tick 24; frame stays 3, busy=0.
- loop_en=1 -> frame wraps 3 to 0 with no done. start coincident with tick -> frame=0, hold=0.
- SPRITE_HFLIP_EN defined, hflip=1, lx=0 -> address column 63. Undefined -> column 0.
